nn_fwd_sequencer: RTL and testbench

Control FSM that sequences one forward pass of the fully-connected MLP inside `network_top`. It generates the ROM read addresses for:
- the input image (`addr_in`),
- input→hidden weights (`addr_ih`),
- hidden→output weights (`addr_ho`).

It also drives the MAC clear/enable strobes and the write-back strobes for the hidden activation buffer and the ten output registers. It replaces ad-hoc address counting so that one datapath MAC is time-shared across both layers.

---
 rtl/nn_pkg.sv | 26 ++
 rtl/nn_fwd_sequencer_if.sv | 37 +++
 rtl/nn_idx_counter.sv | 36 +++
 rtl/nn_fwd_sequencer.sv | 151 +++++++++++++++
 tb/tb_nn_fwd_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the forward-pass sequencer: FSM state encoding,
// default network dimensions and the fixed ROM / hidden-buffer latency.
package nn_pkg;

  localparam int N_IN_DEF  = 784;
  localparam int N_HID_DEF = 32;
  localparam int N_OUT_DEF = 10;

  // ROM and hidden buffer return data one cycle after the address, which is
  // why each layer's DRAIN phase is exactly one cycle long.
  localparam int ROM_LAT = 1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    H_CLR   = 4'd1,
    H_MAC   = 4'd2,
    H_DRAIN = 4'd3,
    H_WB    = 4'd4,
    O_CLR   = 4'd5,
    O_MAC   = 4'd6,
    O_DRAIN = 4'd7,
    O_WB    = 4'd8,
    DONE    = 4'd9
  } state_t;

endpackage

// File: rtl/nn_fwd_sequencer_if.sv
// Control/address bundle between the pass requester (master) and the
// forward-pass sequencer (slave).
interface nn_fwd_sequencer_if #(
  parameter int AW = 17,
  parameter int HW = 5
);

  logic          start;
  logic          abort;
  logic [AW-1:0] img_base;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] addr_ih;
  logic [AW-1:0] addr_ho;
  logic [HW-1:0] hid_raddr;
  logic          mac_clr;
  logic          mac_en;
  logic          mac_sel;
  logic          act_we;
  logic [HW-1:0] hid_widx;
  logic          out_we;
  logic [HW-1:0] out_idx;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, img_base,
    input  addr_in, addr_ih, addr_ho, hid_raddr, mac_clr, mac_en, mac_sel,
           act_we, hid_widx, out_we, out_idx, busy, done
  );

  modport slave (
    input  start, abort, img_base,
    output addr_in, addr_ih, addr_ho, hid_raddr, mac_clr, mac_en, mac_sel,
           act_we, hid_widx, out_we, out_idx, busy, done
  );

endinterface

// File: rtl/nn_idx_counter.sv
// Loadable up-counter with synchronous clear, programmable step and a
// terminal-count flag. Used for loop indices, weight-base accumulators and
// the registered ROM address outputs. Arithmetic wraps modulo 2^W.
module nn_idx_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         inc,
  input  logic [W-1:0] step,
  input  logic [W-1:0] last,
  output logic [W-1:0] q,
  output logic         tc
);

  // Count register: clear beats load beats increment.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (inc) begin
      q <= q + step;
    end
  end

  assign tc = (q == last);

endmodule

// File: rtl/nn_fwd_sequencer.sv
// Forward-pass sequencer for the time-shared MLP MAC. Walks every hidden
// neuron (N_IN products each) and then every output neuron (N_HID products
// each), producing ROM addresses, MAC strobes and write-back strobes.
// All outputs are registered and change together with the state.
module nn_fwd_sequencer
  import nn_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_HID = N_HID_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int AW    = 17,
  parameter int HW    = 5
) (
  input logic               clk,
  input logic               rst,
  nn_fwd_sequencer_if.slave bus
);

  // Inner-loop index must reach N_IN (or N_HID) without overflowing.
  localparam int IW = $clog2((N_IN > N_HID) ? N_IN : N_HID) + 1;

  state_t state_q, state_d;

  logic [AW-1:0] img_q;
  logic [IW-1:0] idx_q, idx_last;
  logic          idx_tc, idx_clr, idx_inc;
  logic [HW-1:0] nidx_q, nidx_last;
  logic          nidx_tc, nidx_clr, nidx_inc;
  logic [AW-1:0] ih_base_q, ho_base_q;
  logic          go_idle, run_h, run_o;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned, which would
    // otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = H_CLR;
      H_CLR:   state_d = H_MAC;
      H_MAC:   if (idx_tc) state_d = H_DRAIN;
      H_DRAIN: state_d = H_WB;
      H_WB:    state_d = nidx_tc ? O_CLR : H_CLR;
      O_CLR:   state_d = O_MAC;
      O_MAC:   if (idx_tc) state_d = O_DRAIN;
      O_DRAIN: state_d = O_WB;
      O_WB:    state_d = nidx_tc ? DONE : O_CLR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  // Counter controls. Everything is zeroed whenever the FSM heads to IDLE,
  // so a fresh pass always starts from clean counters.
  assign go_idle   = (state_d == IDLE);
  assign run_h     = (state_q == H_MAC) && !idx_tc;
  assign run_o     = (state_q == O_MAC) && !idx_tc;
  assign idx_clr   = go_idle || (state_q == H_CLR) || (state_q == O_CLR);
  assign idx_inc   = (state_q == H_MAC) || (state_q == O_MAC);
  assign idx_last  = (state_q == O_MAC) ? IW'(N_HID - 1) : IW'(N_IN - 1);
  assign nidx_clr  = go_idle || ((state_q == H_WB) && nidx_tc);
  assign nidx_inc  = ((state_q == H_WB) || (state_q == O_WB)) && !nidx_tc;
  assign nidx_last = (state_q == H_WB) ? HW'(N_HID - 1) : HW'(N_OUT - 1);

  // Image base is captured only when a pass is actually accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           img_q <= '0;
    else if (state_q == IDLE && bus.start && !bus.abort) img_q <= bus.img_base;
  end

  // i / h: position inside the current MAC run.
  nn_idx_counter #(.W(IW)) u_idx (
    .clk(clk), .rst(rst), .clr(idx_clr), .load(1'b0), .din('0),
    .inc(idx_inc), .step(IW'(1)), .last(idx_last), .q(idx_q), .tc(idx_tc)
  );

  // j / k: neuron index within the current layer.
  nn_idx_counter #(.W(HW)) u_nidx (
    .clk(clk), .rst(rst), .clr(nidx_clr), .load(1'b0), .din('0),
    .inc(nidx_inc), .step(HW'(1)), .last(nidx_last), .q(nidx_q), .tc(nidx_tc)
  );

  // Weight row bases: running sums replace j*N_IN and k*N_HID.
  nn_idx_counter #(.W(AW)) u_ih_base (
    .clk(clk), .rst(rst), .clr(go_idle), .load(1'b0), .din('0),
    .inc(state_q == H_WB), .step(AW'(N_IN)), .last('0), .q(ih_base_q), .tc()
  );

  nn_idx_counter #(.W(AW)) u_ho_base (
    .clk(clk), .rst(rst), .clr(go_idle), .load(1'b0), .din('0),
    .inc(state_q == O_WB), .step(AW'(N_HID)), .last('0), .q(ho_base_q), .tc()
  );

  // Address outputs: loaded on the edge entering the first MAC cycle,
  // stepped on each following MAC cycle, held otherwise.
  nn_idx_counter #(.W(AW)) u_addr_in (
    .clk(clk), .rst(rst), .clr(go_idle), .load(state_q == H_CLR), .din(img_q),
    .inc(run_h), .step(AW'(1)), .last('0), .q(bus.addr_in), .tc()
  );

  nn_idx_counter #(.W(AW)) u_addr_ih (
    .clk(clk), .rst(rst), .clr(go_idle), .load(state_q == H_CLR), .din(ih_base_q),
    .inc(run_h), .step(AW'(1)), .last('0), .q(bus.addr_ih), .tc()
  );

  nn_idx_counter #(.W(AW)) u_addr_ho (
    .clk(clk), .rst(rst), .clr(go_idle), .load(state_q == O_CLR), .din(ho_base_q),
    .inc(run_o), .step(AW'(1)), .last('0), .q(bus.addr_ho), .tc()
  );

  nn_idx_counter #(.W(HW)) u_hid_raddr (
    .clk(clk), .rst(rst), .clr(go_idle), .load(state_q == O_CLR), .din('0),
    .inc(run_o), .step(HW'(1)), .last('0), .q(bus.hid_raddr), .tc()
  );

  // Registered strobes, decoded from the state being entered so they line
  // up with it. An abort sends state_d to IDLE, which suppresses every
  // strobe (including write-backs and done) in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mac_clr  <= 1'b0;
      bus.mac_en   <= 1'b0;
      bus.mac_sel  <= 1'b0;
      bus.act_we   <= 1'b0;
      bus.hid_widx <= '0;
      bus.out_we   <= 1'b0;
      bus.out_idx  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.mac_clr  <= (state_d == H_CLR) || (state_d == O_CLR);
      // Data for MAC cycle n arrives in cycle n+1, so enable trails by one.
      bus.mac_en   <= ((state_q == H_MAC) || (state_q == O_MAC)) && !go_idle;
      bus.mac_sel  <= (state_d == O_CLR) || (state_d == O_MAC) ||
                      (state_d == O_DRAIN) || (state_d == O_WB);
      bus.act_we   <= (state_d == H_WB);
      bus.hid_widx <= (state_d == H_WB) ? nidx_q : '0;
      bus.out_we   <= (state_d == O_WB);
      bus.out_idx  <= (state_d == O_WB) ? nidx_q : '0;
      bus.busy     <= (state_d != IDLE) && (state_d != DONE);
      bus.done     <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_nn_fwd_sequencer.sv
// Self-checking bench for nn_fwd_sequencer on a small 4-3-2 network.
// Expected behaviour comes from the pass timeline: per neuron CLR, MAC run,
// DRAIN, WB; cycle 1 is the cycle after the accepting edge.
module tb_nn_fwd_sequencer;

  localparam int N_IN     = 4;
  localparam int N_HID    = 3;
  localparam int N_OUT    = 2;
  localparam int AW       = 17;
  localparam int AWW      = 4;
  localparam int HW       = 5;
  localparam int SEG_H    = N_IN + 3;
  localparam int SEG_O    = N_HID + 3;
  localparam int H_LEN    = N_HID * SEG_H;
  localparam int PASS_LEN = 1 + H_LEN + N_OUT * SEG_O;
  localparam int OW       = 3 * AW + 3 * HW + 7;
  localparam int OWW      = 3 * AWW + 3 * HW + 7;

  typedef struct {
    logic clr, en, awe, owe, done, busy, sel_chk, sel, mac_h, mac_o;
    int   i, j, k, h;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  nn_fwd_sequencer_if #(.AW(AW),  .HW(HW)) bus ();
  nn_fwd_sequencer_if #(.AW(AWW), .HW(HW)) bus_w ();

  nn_fwd_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .AW(AW), .HW(HW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  nn_fwd_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .AW(AWW), .HW(HW)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] main_outs();
    return {bus.addr_in, bus.addr_ih, bus.addr_ho, bus.hid_raddr, bus.mac_clr, bus.mac_en,
            bus.mac_sel, bus.act_we, bus.hid_widx, bus.out_we, bus.out_idx, bus.busy, bus.done};
  endfunction

  function automatic logic [OWW-1:0] wrap_outs();
    return {bus_w.addr_in, bus_w.addr_ih, bus_w.addr_ho, bus_w.hid_raddr, bus_w.mac_clr,
            bus_w.mac_en, bus_w.mac_sel, bus_w.act_we, bus_w.hid_widx, bus_w.out_we,
            bus_w.out_idx, bus_w.busy, bus_w.done};
  endfunction

  // Reference timeline: what the outputs must be in cycle c of a pass.
  function automatic exp_t model(input int c);
    exp_t e;
    int off, p;
    e.clr = 0; e.en = 0; e.awe = 0; e.owe = 0; e.done = 0; e.busy = 0;
    e.sel_chk = 0; e.sel = 0; e.mac_h = 0; e.mac_o = 0;
    e.i = 0; e.j = 0; e.k = 0; e.h = 0;
    if (c >= 1 && c <= H_LEN) begin
      off = c - 1; p = off % SEG_H;
      e.j = off / SEG_H; e.i = p - 1;
      e.clr = (p == 0); e.mac_h = (p >= 1 && p <= N_IN);
      e.en = (p >= 2 && p <= N_IN + 1); e.awe = (p == N_IN + 2);
      e.sel_chk = 1; e.sel = 0; e.busy = 1;
    end else if (c > H_LEN && c < PASS_LEN) begin
      off = c - 1 - H_LEN; p = off % SEG_O;
      e.k = off / SEG_O; e.h = p - 1;
      e.clr = (p == 0); e.mac_o = (p >= 1 && p <= N_HID);
      e.en = (p >= 2 && p <= N_HID + 1); e.owe = (p == N_HID + 2);
      e.sel_chk = 1; e.sel = 1; e.busy = 1;
    end else if (c == PASS_LEN) begin
      e.done = 1;
    end
    return e;
  endfunction

  task automatic compare_to_model(input int c, input int base, input string tag);
    exp_t e;
    logic [4:0] got_s, exp_s;
    logic [AW-1:0] ea;
    e = model(c);
    got_s = {bus.mac_clr, bus.mac_en, bus.act_we, bus.out_we, bus.done};
    exp_s = {e.clr, e.en, e.awe, e.owe, e.done};
    total++;
    if (got_s !== exp_s) begin
      bad++;
      $display("FAIL %s strobes c=%0d got=%b want=%b (clr,en,act_we,out_we,done)", tag, c, got_s, exp_s);
    end
    if (c < PASS_LEN) begin
      total++;
      if (bus.busy !== e.busy) begin
        bad++; $display("FAIL %s busy c=%0d got=%b want=%b", tag, c, bus.busy, e.busy);
      end
    end
    if (e.sel_chk) begin
      total++;
      if (bus.mac_sel !== e.sel) begin
        bad++; $display("FAIL %s mac_sel c=%0d got=%b want=%b", tag, c, bus.mac_sel, e.sel);
      end
    end
    if (e.awe) begin
      total++;
      if (bus.hid_widx !== HW'(e.j)) begin
        bad++; $display("FAIL %s hid_widx c=%0d got=%0d want=%0d", tag, c, bus.hid_widx, e.j);
      end
    end
    if (e.owe) begin
      total++;
      if (bus.out_idx !== HW'(e.k)) begin
        bad++; $display("FAIL %s out_idx c=%0d got=%0d want=%0d", tag, c, bus.out_idx, e.k);
      end
    end
    if (e.mac_h) begin
      ea = AW'(base + e.i);
      total++;
      if (bus.addr_in !== ea) begin
        bad++; $display("FAIL %s addr_in c=%0d got=%0d want=%0d", tag, c, bus.addr_in, ea);
      end
      ea = AW'(e.j * N_IN + e.i);
      total++;
      if (bus.addr_ih !== ea) begin
        bad++; $display("FAIL %s addr_ih c=%0d got=%0d want=%0d", tag, c, bus.addr_ih, ea);
      end
    end
    if (e.mac_o) begin
      ea = AW'(e.k * N_HID + e.h);
      total++;
      if (bus.addr_ho !== ea) begin
        bad++; $display("FAIL %s addr_ho c=%0d got=%0d want=%0d", tag, c, bus.addr_ho, ea);
      end
      total++;
      if (bus.hid_raddr !== HW'(e.h)) begin
        bad++; $display("FAIL %s hid_raddr c=%0d got=%0d want=%0d", tag, c, bus.hid_raddr, e.h);
      end
    end
  endtask

  // Leaves the bench at the falling edge inside cycle 1 of the new pass.
  task automatic start_pass(input int base);
    @(negedge clk);
    bus.img_base = AW'(base);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Checks cycles 1..PASS_LEN; ends at the falling edge of the done cycle.
  task automatic run_checked(input int base, input string tag);
    for (int c = 1; c <= PASS_LEN; c++) begin
      compare_to_model(c, base, tag);
      if (c < PASS_LEN) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (main_outs() !== '0) begin
      bad++; $display("FAIL reset_outs got=%h want=0", main_outs());
    end
    total++;
    if (wrap_outs() !== '0) begin
      bad++; $display("FAIL reset_outs_w got=%h want=0", wrap_outs());
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (main_outs() !== '0) begin
      bad++; $display("FAIL idle_outs got=%h want=0", main_outs());
    end
  endtask

  task automatic test_full_pass();
    start_pass(100);
    run_checked(100, "full");
    @(negedge clk);
    total++;
    if (main_outs() !== '0) begin
      bad++; $display("FAIL full_idle_after got=%h want=0", main_outs());
    end
  endtask

  task automatic test_enable_count();
    int q_got[$];
    int q_exp[$];
    int cnt, first_addr, first_en;
    bit open;
    cnt = 0; open = 0; first_addr = -1; first_en = -1;
    for (int n = 0; n < N_HID; n++) q_exp.push_back(N_IN);
    for (int n = 0; n < N_OUT; n++) q_exp.push_back(N_HID);
    start_pass(100);
    for (int c = 1; c <= PASS_LEN; c++) begin
      if (bus.mac_clr === 1'b1) begin
        if (open) q_got.push_back(cnt);
        cnt = 0; open = 1;
      end
      if (bus.mac_en === 1'b1) begin
        cnt++;
        if (first_en < 0) first_en = c;
      end
      if (bus.addr_in === AW'(100) && first_addr < 0) first_addr = c;
      @(negedge clk);
    end
    if (open) q_got.push_back(cnt);
    total++;
    if (q_got.size() != q_exp.size()) begin
      bad++; $display("FAIL en_groups got=%0d want=%0d", q_got.size(), q_exp.size());
    end else begin
      foreach (q_exp[n]) begin
        total++;
        if (q_got[n] != q_exp[n]) begin
          bad++; $display("FAIL en_count group=%0d got=%0d want=%0d", n, q_got[n], q_exp[n]);
        end
      end
    end
    total++;
    if (first_addr != 2) begin
      bad++; $display("FAIL first_addr_cycle got=%0d want=2", first_addr);
    end
    total++;
    if (first_en != first_addr + 1) begin
      bad++; $display("FAIL first_en_cycle got=%0d want=%0d", first_en, first_addr + 1);
    end
  endtask

  task automatic test_back_to_back();
    int b1, b2;
    b1 = int'($urandom_range(131071, 0));
    b2 = int'($urandom_range(131071, 0));
    start_pass(b1);
    run_checked(b1, "b2b_first");
    @(negedge clk);
    bus.img_base = AW'(b2);
    bus.start = 1'b1;
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL b2b_idle_gap got=%b want=00", {bus.busy, bus.done});
    end
    @(negedge clk);
    bus.start = 1'b0;
    run_checked(b2, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_abort();
    int ac, base, base2, dn, aw;
    base  = int'($urandom_range(131071, 0));
    base2 = int'($urandom_range(131071, 0));
    ac = SEG_H + 2 + int'($urandom_range(N_IN - 1, 0));
    dn = 0; aw = 0;
    start_pass(base);
    for (int c = 1; c <= ac; c++) begin
      compare_to_model(c, base, "abort_pre");
      if (c < ac) @(negedge clk);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++;
    if (main_outs() !== '0) begin
      bad++; $display("FAIL abort_idle got=%h want=0", main_outs());
    end
    for (int n = 0; n < PASS_LEN + 4; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
      if (bus.act_we === 1'b1) aw++;
    end
    total++;
    if (dn != 0) begin
      bad++; $display("FAIL abort_done got=%0d want=0", dn);
    end
    total++;
    if (aw != 0) begin
      bad++; $display("FAIL abort_act_we got=%0d want=0", aw);
    end
    start_pass(base2);
    run_checked(base2, "abort_restart");
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int dn;
    dn = 0;
    start_pass(100);
    for (int c = 1; c <= PASS_LEN + 4; c++) begin
      if (c <= PASS_LEN) compare_to_model(c, 100, "stray_start");
      if (c == 10) begin
        bus.img_base = AW'($urandom_range(131071, 200));
        bus.start = 1'b1;
      end
      if (c == 11) bus.start = 1'b0;
      if (bus.done === 1'b1) dn++;
      @(negedge clk);
    end
    total++;
    if (dn != 1) begin
      bad++; $display("FAIL stray_done_pulses got=%0d want=1", dn);
    end
  endtask

  task automatic test_async_reset();
    int rc, base, base2;
    base  = int'($urandom_range(131071, 0));
    base2 = int'($urandom_range(131071, 0));
    rc = H_LEN + 2 + int'($urandom_range(N_HID - 1, 0));
    start_pass(base);
    for (int c = 1; c <= rc; c++) begin
      compare_to_model(c, base, "arst_pre");
      if (c < rc) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (main_outs() !== '0) begin
      bad++; $display("FAIL arst_immediate got=%h want=0", main_outs());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (main_outs() !== '0) begin
      bad++; $display("FAIL arst_idle got=%h want=0", main_outs());
    end
    start_pass(base2);
    run_checked(base2, "arst_restart");
    @(negedge clk);
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [AWW-1:0] ea;
    @(negedge clk);
    bus_w.img_base = AWW'(14);
    bus_w.start = 1'b1;
    @(negedge clk);
    bus_w.start = 1'b0;
    for (int c = 1; c <= PASS_LEN + 2; c++) begin
      e = model(c);
      if (e.mac_h) begin
        ea = AWW'(14 + e.i);
        total++;
        if (bus_w.addr_in !== ea) begin
          bad++; $display("FAIL wrap_addr_in c=%0d got=%0d want=%0d", c, bus_w.addr_in, ea);
        end
        ea = AWW'(e.j * N_IN + e.i);
        total++;
        if (bus_w.addr_ih !== ea) begin
          bad++; $display("FAIL wrap_addr_ih c=%0d got=%0d want=%0d", c, bus_w.addr_ih, ea);
        end
      end
      total++;
      if (bus_w.done !== e.done) begin
        bad++; $display("FAIL wrap_done c=%0d got=%b want=%b", c, bus_w.done, e.done);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.start = 1'b0;   bus.abort = 1'b0;   bus.img_base = '0;
    bus_w.start = 1'b0; bus_w.abort = 1'b0; bus_w.img_base = '0;
    test_reset();
    test_full_pass();
    test_enable_count();
    test_back_to_back();
    test_abort();
    test_start_ignored();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
